pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
Parametrised successor to the fixed-field IF/ID/EX/MEM stage registers. It is a generic inter-stage pipeline register carrying an opaque payload of DATA_W bits plus a ROB index, with a valid/ready handshake replacing the global d-cache stall.
- A 2-entry skid buffer gives full throughput with a registered upstream ready.
- Supports a full flush (branch/exception), plus a selective kill of entries younger than a given ROB index.
- Includes a stall-cycle performance counter.

Parameters:
DATA_W, 128, payload width in bits (packed control and data fields of the stage)
ROB_IDX_W, 4, ROB index width; ROB depth is 2**ROB_IDX_W
ZERO_ON_INVALID, 1, if 1, payload and ROB index outputs are forced to 0 whenever out_valid=0
CNT_W, 32, width of the stall performance counter

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
in_valid  in  1  upstream presents an entry
in_data  in  DATA_W  upstream payload
in_rob_idx  in  ROB_IDX_W  ROB index of the upstream entry
out_ready  out  1  stage can accept an entry; registered (no combinational path from in_ready)
out_valid  out  1  head entry valid toward downstream
out_data  out  DATA_W  head payload
out_rob_idx  out  ROB_IDX_W  head ROB index
in_ready  in  1  downstream accepts the head this cycle
in_flush  in  1  drop every held entry and any incoming entry
in_kill_valid  in  1  selective kill request
in_kill_idx  in  ROB_IDX_W  kill entries strictly younger than this index
in_rob_head  in  ROB_IDX_W  current ROB head, used for age comparison
out_occupancy  out  2  number of valid entries (0..2)
out_stall_cycles  out  CNT_W  cycles with out_valid=1 and in_ready=0

Behaviour:
- Storage: main register (drives the outputs) and skid register, each with its own valid bit.
- States: EMPTY (0 entries), ONE (main only), TWO (main+skid). The skid is never valid while main is invalid.
- out_ready = !skid_valid. Push occurs when in_valid && out_ready. Pop occurs when out_valid && in_ready.
- Transitions, with no flush or kill:
  - EMPTY+push -> ONE.
  - ONE+push+pop -> ONE (new entry loads main).
  - ONE+push+!pop -> TWO (new entry loads skid).
  - ONE+pop -> EMPTY.
  - TWO+pop -> ONE (skid moves to main; push is impossible since out_ready=0).
  - TWO+!pop -> TWO, with the payload held stable.
- Latency: 1 cycle from push to out_valid when EMPTY. Sustained throughput: 1 entry/cycle.
- Order is strictly FIFO. Payload and index are never modified while valid.
- Age rule:
  - age(x) = (x - in_rob_head) mod 2**ROB_IDX_W.
  - An entry is younger than K when age(idx) > age(K). Equal age is not killed.
- Kill, when in_kill_valid=1:
  - Clear the valid bit of every held entry younger than in_kill_idx.
  - Suppress a same-cycle push whose in_rob_idx is younger.
  - If main is killed but skid survives: impossible by FIFO age order; the RTL asserts it.
  - If skid is killed and main survives: go to ONE.
  - A pop in the same cycle as a kill still completes if the head is not killed.
- Flush, when in_flush=1:
  - All valid bits go to 0 next cycle and any push is dropped.
  - Flush dominates kill and push; a same-cycle pop is still reported but its entry leaves regardless.
- ZERO_ON_INVALID=1: invalidated registers are also zeroed, matching existing bubble semantics where the stage outputs all-zero control fields.
- Reset (dominates everything): valids=0, out_data=0, out_rob_idx=0, out_ready=1 on the cycle after reset, out_occupancy=0, out_stall_cycles=0. Reset asserted mid-transfer discards all entries.
- out_stall_cycles:
  - Increments by 1 each cycle with out_valid && !in_ready.
  - Saturates at all-ones; no wrap.
  - Cleared only by reset.
- No combinational path from in_* to out_* except that out_data/out_rob_idx/out_valid are direct register outputs.

Decomposition:
- Shared pipeline package holds the following, so the existing fixed stage registers can be rebuilt as typedef-wrapped instances:
  - ROB_IDX_W and the ROB depth constant.
  - The rob_age function.
  - The packed payload struct typedefs per stage (idex_payload_t etc.).
- One sub-module, rob_age_cmp (combinational younger-than compare), is instantiated three times: main, skid and incoming.

Test Plan:
- Idle: reset, then push A (idx 3) with in_ready=1 -> out_valid=1, out_data=A one cycle later; occupancy stays 1 under streaming 1/cycle for 10 entries with no gaps.
- Back-pressure: push A, B with in_ready=0 -> occupancy=2, out_ready=0, out_stall_cycles counts 1 per cycle. Raise in_ready -> A then B emerge in order, out_ready returns to 1 after A pops.
- Flush: occupancy=2 plus push pending, pulse in_flush -> next cycle out_valid=0, out_data=0, occupancy=0, incoming entry absent.
- Kill with wrap: head=14, main idx=15, skid idx=1, kill_idx=0 -> skid dropped, main kept, occupancy=1. With kill_idx=15, main is kept (equal age not killed).
- Kill on push: EMPTY, push idx 5 with kill_idx=4 (head=0) in the same cycle -> push suppressed, out_valid=0.
- Reset mid-operation: occupancy=2, stall counter=7, assert reset for 1 cycle -> all outputs 0, out_ready=1; counter saturation is checked with CNT_W=3 (7 stays 7).

Source files
------------

// File: rtl/pipe_stage_elastic_pkg.sv
// Shared pipeline definitions: ROB sizing, ROB age arithmetic and per-stage payload layouts.
package pipe_stage_elastic_pkg;

  localparam int ROB_IDX_W = 4;
  localparam int ROB_DEPTH = 1 << ROB_IDX_W;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_payload_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [19:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } idex_payload_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } exmem_payload_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_wr;
  } memwb_payload_t;

  // Distance of idx behind the ROB head, modulo the ROB depth of the given index width.
  function automatic logic [31:0] rob_age(input logic [31:0] idx, input logic [31:0] head,
                                          input int unsigned width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return (idx - head) & mask;
  endfunction

endpackage

// File: rtl/pipe_stage_elastic_age_cmp.sv
// Combinational "idx is strictly younger than ref" compare relative to the ROB head.
module rob_age_cmp
  import pipe_stage_elastic_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] idx_i,
  input  logic [W-1:0] ref_i,
  input  logic [W-1:0] head_i,
  output logic         younger_o
);

  logic [31:0] age_idx_s;
  logic [31:0] age_ref_s;

  assign age_idx_s = rob_age(32'(idx_i), 32'(head_i), W);
  assign age_ref_s = rob_age(32'(ref_i), 32'(head_i), W);
  assign younger_o = (age_idx_s > age_ref_s);

endmodule

// File: rtl/pipe_stage_elastic_chk.sv
// Structural invariants of the elastic stage: skid implies main, and kills respect FIFO age order.
module pipe_stage_elastic_chk (
  input logic clk,
  input logic reset,
  input logic main_valid_i,
  input logic skid_valid_i,
  input logic kill_main_i,
  input logic kill_skid_i
);

  a_skid_needs_main: assert property (@(posedge clk) disable iff (reset)
    skid_valid_i |-> main_valid_i);

  // The skid entry is always younger than main, so it cannot survive a kill that takes main.
  a_kill_age_order: assert property (@(posedge clk) disable iff (reset)
    (kill_main_i && skid_valid_i) |-> kill_skid_i);

endmodule

// File: rtl/pipe_stage_elastic.sv
// Generic elastic inter-stage register: 2-entry skid buffer, flush, age-based kill, stall counter.
module pipe_stage_elastic #(
  parameter int DATA_W          = 128,
  parameter int ROB_IDX_W       = pipe_stage_elastic_pkg::ROB_IDX_W,
  parameter bit ZERO_ON_INVALID = 1'b1,
  parameter int CNT_W           = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [ROB_IDX_W-1:0] in_rob_idx,
  output logic                 out_ready,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic [ROB_IDX_W-1:0] out_rob_idx,
  input  logic                 in_ready,
  input  logic                 in_flush,
  input  logic                 in_kill_valid,
  input  logic [ROB_IDX_W-1:0] in_kill_idx,
  input  logic [ROB_IDX_W-1:0] in_rob_head,
  output logic [1:0]           out_occupancy,
  output logic [CNT_W-1:0]     out_stall_cycles
);

  logic                 main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0]    main_data_q, main_data_d, main_data_s;
  logic [DATA_W-1:0]    skid_data_q, skid_data_d, skid_data_s;
  logic [ROB_IDX_W-1:0] main_idx_q, main_idx_d, main_idx_s;
  logic [ROB_IDX_W-1:0] skid_idx_q, skid_idx_d, skid_idx_s;
  logic                 ready_q, ready_d;
  logic [CNT_W-1:0]     stall_q, stall_d;
  logic main_young_s, skid_young_s, in_young_s;
  logic push_s, pop_s, kill_main_s, kill_skid_s, push_live_s, keep_main_s, skid_live_s;

  rob_age_cmp #(.W(ROB_IDX_W)) u_cmp_main (
    .idx_i(main_idx_q), .ref_i(in_kill_idx), .head_i(in_rob_head), .younger_o(main_young_s)
  );
  rob_age_cmp #(.W(ROB_IDX_W)) u_cmp_skid (
    .idx_i(skid_idx_q), .ref_i(in_kill_idx), .head_i(in_rob_head), .younger_o(skid_young_s)
  );
  rob_age_cmp #(.W(ROB_IDX_W)) u_cmp_in (
    .idx_i(in_rob_idx), .ref_i(in_kill_idx), .head_i(in_rob_head), .younger_o(in_young_s)
  );

  assign push_s      = in_valid && ready_q;
  assign pop_s       = main_valid_q && in_ready;
  assign kill_main_s = in_kill_valid && main_valid_q && main_young_s;
  assign kill_skid_s = in_kill_valid && skid_valid_q && skid_young_s;
  assign push_live_s = push_s && !(in_kill_valid && in_young_s);
  assign keep_main_s = main_valid_q && !kill_main_s && !pop_s;
  assign skid_live_s = skid_valid_q && !kill_skid_s;

  // Surviving entries are compacted in FIFO order: kept main, then surviving skid, then the push.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_s  = main_data_q;
    main_idx_s   = main_idx_q;
    skid_valid_d = skid_valid_q;
    skid_data_s  = skid_data_q;
    skid_idx_s   = skid_idx_q;
    if (in_flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (keep_main_s) begin
      skid_valid_d = skid_live_s || push_live_s;
      if (!skid_live_s) begin
        skid_data_s = in_data;
        skid_idx_s  = in_rob_idx;
      end else begin
        skid_data_s = skid_data_q;
        skid_idx_s  = skid_idx_q;
      end
    end else if (skid_live_s) begin
      main_valid_d = 1'b1;
      main_data_s  = skid_data_q;
      main_idx_s   = skid_idx_q;
      skid_valid_d = 1'b0;
    end else begin
      main_valid_d = push_live_s;
      main_data_s  = in_data;
      main_idx_s   = in_rob_idx;
      skid_valid_d = 1'b0;
    end
  end

  assign main_data_d = (ZERO_ON_INVALID && !main_valid_d) ? '0 : main_data_s;
  assign main_idx_d  = (ZERO_ON_INVALID && !main_valid_d) ? '0 : main_idx_s;
  assign skid_data_d = (ZERO_ON_INVALID && !skid_valid_d) ? '0 : skid_data_s;
  assign skid_idx_d  = (ZERO_ON_INVALID && !skid_valid_d) ? '0 : skid_idx_s;
  assign ready_d     = !skid_valid_d;

  // Saturating count of cycles where the head is offered but not taken.
  always_comb begin
    if (main_valid_q && !in_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_d = stall_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_idx_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_idx_q   <= '0;
      ready_q      <= 1'b1;
      stall_q      <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_idx_q   <= main_idx_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_idx_q   <= skid_idx_d;
      ready_q      <= ready_d;
      stall_q      <= stall_d;
    end
  end

  assign out_ready        = ready_q;
  assign out_valid        = main_valid_q;
  assign out_data         = main_data_q;
  assign out_rob_idx      = main_idx_q;
  assign out_occupancy    = {skid_valid_q, main_valid_q & ~skid_valid_q};
  assign out_stall_cycles = stall_q;

  pipe_stage_elastic_chk u_chk (
    .clk         (clk),
    .reset       (reset),
    .main_valid_i(main_valid_q),
    .skid_valid_i(skid_valid_q),
    .kill_main_i (kill_main_s),
    .kill_skid_i (kill_skid_s)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Randomised + directed bench for pipe_stage_elastic with a queue-based reference model and scoreboard.
module tb_pipe_stage_elastic;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   idx;
  } ent_t;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [127:0] in_data;
  logic [3:0]   in_rob_idx;
  logic         in_ready;
  logic         in_flush;
  logic         in_kill_valid;
  logic [3:0]   in_kill_idx;
  logic [3:0]   in_rob_head;
  logic         out_ready, out_valid;
  logic [127:0] out_data;
  logic [3:0]   out_rob_idx;
  logic [1:0]   out_occupancy;
  logic [31:0]  out_stall_cycles;
  logic         s_ready, s_valid;
  logic [127:0] s_data;
  logic [3:0]   s_idx;
  logic [1:0]   s_occ;
  logic [2:0]   s_stall;

  ent_t    mq[$];
  ent_t    exp_q[$];
  longint  m_stall;
  int      m_stall3;
  int      checks;
  int      errors;

  pipe_stage_elastic dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_rob_idx(in_rob_idx),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_rob_idx(out_rob_idx),
    .in_ready(in_ready), .in_flush(in_flush), .in_kill_valid(in_kill_valid),
    .in_kill_idx(in_kill_idx), .in_rob_head(in_rob_head), .out_occupancy(out_occupancy),
    .out_stall_cycles(out_stall_cycles)
  );

  pipe_stage_elastic #(.CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_rob_idx(in_rob_idx),
    .out_ready(s_ready), .out_valid(s_valid), .out_data(s_data), .out_rob_idx(s_idx),
    .in_ready(in_ready), .in_flush(in_flush), .in_kill_valid(in_kill_valid),
    .in_kill_idx(in_kill_idx), .in_rob_head(in_rob_head), .out_occupancy(s_occ),
    .out_stall_cycles(s_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int age(input int x, input int h);
    return ((x - h) % 16 + 16) % 16;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("hs_pending", 128'(exp_q.size()), 128'd0);
    chk("out_valid", 128'(out_valid), 128'(mq.size() > 0));
    chk("out_ready", 128'(out_ready), 128'(mq.size() < 2));
    chk("occupancy", 128'(out_occupancy), 128'(mq.size()));
    chk("stall_cycles", 128'(out_stall_cycles), 128'(m_stall));
    chk("sat_valid", 128'(s_valid), 128'(mq.size() > 0));
    chk("sat_ready", 128'(s_ready), 128'(mq.size() < 2));
    chk("sat_occupancy", 128'(s_occ), 128'(mq.size()));
    chk("sat_stall", 128'(s_stall), 128'(m_stall3));
    if (mq.size() > 0) begin
      chk("head_data", out_data, mq[0].data);
      chk("head_idx", 128'(out_rob_idx), 128'(mq[0].idx));
      chk("sat_head_idx", 128'(s_idx), 128'(mq[0].idx));
    end else begin
      chk("bubble_data", out_data, 128'd0);
      chk("bubble_idx", 128'(out_rob_idx), 128'd0);
      chk("sat_bubble_data", s_data, 128'd0);
    end
  endtask

  // One clock: drive inputs, advance the reference model, then check the registered state.
  task automatic cycle(input bit rst, input bit v, input logic [127:0] d, input int idx,
                       input bit rdy, input bit fl, input bit kv, input int kidx,
                       input int head, output bit landed);
    ent_t nq[$];
    ent_t e;
    int   sz;
    reset = rst; in_valid = v; in_data = d; in_rob_idx = 4'(idx); in_ready = rdy;
    in_flush = fl; in_kill_valid = kv; in_kill_idx = 4'(kidx); in_rob_head = 4'(head);
    landed = 1'b0;
    if (rst) begin
      mq.delete();
      m_stall = 0;
      m_stall3 = 0;
    end else begin
      sz = mq.size();
      if (sz > 0 && !rdy) begin
        if (m_stall < 64'hFFFF_FFFF) m_stall++;
        if (m_stall3 < 7) m_stall3++;
      end
      nq = mq;
      if (sz > 0 && rdy) exp_q.push_back(nq.pop_front());
      if (kv) begin
        mq.delete();
        foreach (nq[i]) if (age(int'(nq[i].idx), head) <= age(kidx, head)) mq.push_back(nq[i]);
        nq = mq;
      end
      if (fl) begin
        nq.delete();
      end else if (v && sz < 2 && !(kv && age(idx, head) > age(kidx, head))) begin
        e.data = d;
        e.idx = 4'(idx);
        nq.push_back(e);
        landed = 1'b1;
      end
      mq = nq;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  // Scoreboard monitor: every handshake must deliver the next expected entry.
  always @(negedge clk) begin
    ent_t e;
    if (reset === 1'b0 && out_valid === 1'b1 && in_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL hs_unexpected: got idx %0h expected no handshake at %0t", out_rob_idx, $time);
      end else begin
        e = exp_q.pop_front();
        chk("hs_data", out_data, e.data);
        chk("hs_idx", 128'(out_rob_idx), 128'(e.idx));
      end
    end
  end

  initial begin
    bit lnd;
    int nidx;
    int head;
    checks = 0; errors = 0; m_stall = 0; m_stall3 = 0;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_rob_idx = '0; in_ready = 1'b0;
    in_flush = 1'b0; in_kill_valid = 1'b0; in_kill_idx = '0; in_rob_head = '0;
    cycle(1, 0, 128'd0, 0, 0, 0, 0, 0, 0, lnd);
    cycle(1, 0, 128'd0, 0, 0, 0, 0, 0, 0, lnd);

    // Idle then streaming at one entry per cycle.
    cycle(0, 1, 128'hA, 3, 1, 0, 0, 0, 0, lnd);
    for (int i = 0; i < 10; i++) cycle(0, 1, rnd128(), 4 + i, 1, 0, 0, 0, 0, lnd);
    cycle(0, 0, 128'd0, 0, 1, 0, 0, 0, 0, lnd);

    // Back-pressure, then drain in order.
    cycle(0, 1, 128'hA0, 0, 0, 0, 0, 0, 0, lnd);
    cycle(0, 1, 128'hB0, 1, 0, 0, 0, 0, 0, lnd);
    for (int i = 0; i < 3; i++) cycle(0, 1, 128'hC0, 2, 0, 0, 0, 0, 0, lnd);
    cycle(0, 0, 128'd0, 0, 1, 0, 0, 0, 0, lnd);
    cycle(0, 0, 128'd0, 0, 1, 0, 0, 0, 0, lnd);

    // Flush with both slots full and a push pending.
    cycle(0, 1, 128'hC1, 2, 0, 0, 0, 0, 0, lnd);
    cycle(0, 1, 128'hD1, 3, 0, 0, 0, 0, 0, lnd);
    cycle(0, 1, 128'hE1, 4, 0, 1, 0, 0, 0, lnd);

    // Kill across the index wrap with head=14.
    cycle(0, 1, 128'hF15, 15, 0, 0, 0, 0, 14, lnd);
    cycle(0, 1, 128'hF01, 1, 0, 0, 0, 0, 14, lnd);
    cycle(0, 0, 128'd0, 0, 0, 0, 1, 15, 14, lnd);
    cycle(0, 0, 128'd0, 0, 0, 0, 1, 0, 14, lnd);
    cycle(0, 0, 128'd0, 0, 1, 0, 0, 0, 14, lnd);

    // Kill suppresses a same-cycle push.
    cycle(0, 1, 128'h55, 5, 1, 0, 1, 4, 0, lnd);

    // Reset in the middle of traffic with the counter held.
    cycle(0, 1, 128'h71, 6, 0, 0, 0, 0, 6, lnd);
    cycle(0, 1, 128'h72, 7, 0, 0, 0, 0, 6, lnd);
    for (int i = 0; i < 4; i++) cycle(0, 0, 128'd0, 0, 0, 0, 0, 0, 6, lnd);
    cycle(1, 1, 128'h73, 8, 0, 0, 0, 0, 6, lnd);
    cycle(0, 0, 128'd0, 0, 0, 0, 0, 0, 0, lnd);

    // Random traffic with in-order ROB indices and the head tracking the oldest entry.
    nidx = 0;
    for (int n = 0; n < 400; n++) begin
      head = (mq.size() > 0) ? int'(mq[0].idx) : nidx;
      cycle(0, ($urandom_range(0, 3) != 0), rnd128(), nidx, ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 29) == 0), ($urandom_range(0, 7) == 0),
            (head + int'($urandom_range(0, 3))) % 16, head, lnd);
      if (lnd) nidx = (nidx + 1) % 16;
    end
    cycle(0, 0, 128'd0, 0, 1, 0, 0, 0, 0, lnd);
    cycle(0, 0, 128'd0, 0, 1, 0, 0, 0, 0, lnd);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
